cpu_mem_responder: RTL and testbench

//  Memory-side responder for the stack CPU's instruction and data memory ports.
//  - Serves instruction fetches (read_inst_enable/address_memory_inst) and data reads/writes
//    (read_data_enable/write_data_enable/address_memory_data) from two internal word arrays.
//  - Returns read data through a fixed-latency pipeline with one-cycle valid strobes.
//  - Provides a program-load write port so the testbench or a boot loader can fill instruction

---
 rtl/cpu_mem_responder.sv | 139 +++++++++++++
 tb/tb_cpu_mem_responder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: instruction and data memories for the stack CPU.
// Reads are captured at the sampling edge, then delayed READ_LATENCY more
// edges before a one-cycle valid strobe. A program-load port fills
// instruction memory and stays live while rst holds the CPU side idle.

// Fixed-latency read pipeline. Stage 0 captures the array word at the
// request edge. Stage LATENCY is the output register. Each stage's data
// only moves when its upstream valid is set, so the output keeps the last
// word returned.
module cpu_mem_read_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic [LATENCY:0] v_r;
  logic [WIDTH-1:0] d_r [LATENCY+1];

  // Shift request tags and captured words towards the output stage; reset flushes all stages
  always_ff @(posedge clk) begin
    if (rst) begin
      v_r <= '0;
      for (int i = 0; i <= LATENCY; i++) begin
        d_r[i] <= '0;
      end
    end else begin
      v_r <= {v_r[LATENCY-1:0], req};
      if (req) begin
        d_r[0] <= rdata;
      end
      for (int i = 1; i <= LATENCY; i++) begin
        if (v_r[i-1]) begin
          d_r[i] <= d_r[i-1];
        end
      end
    end
  end

  assign valid = v_r[LATENCY];
  assign data  = d_r[LATENCY];

endmodule

module cpu_mem_responder #(
  parameter int WIDTH_DATA   = 32,
  parameter int AWIDTH       = 5,
  parameter int DAWIDTH      = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_inst_enable,
  input  logic [AWIDTH-1:0]     address_memory_inst,
  output logic [WIDTH_DATA-1:0] instruction,
  output logic                  inst_valid,
  input  logic                  read_data_enable,
  input  logic                  write_data_enable,
  input  logic [DAWIDTH-1:0]    address_memory_data,
  input  logic [WIDTH_DATA-1:0] memory_data_out,
  output logic [WIDTH_DATA-1:0] memory_data_in,
  output logic                  data_valid,
  input  logic                  prog_we,
  input  logic [AWIDTH-1:0]     prog_addr,
  input  logic [WIDTH_DATA-1:0] prog_data,
  output logic                  err_conflict
);

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("cpu_mem_responder: READ_LATENCY must be within 1..4");
    end
  endgenerate

  logic [WIDTH_DATA-1:0] mem_inst [2**AWIDTH];
  logic [WIDTH_DATA-1:0] mem_data [2**DAWIDTH];

  logic inst_req_s;
  logic data_req_s;
  logic data_wr_s;

  // CPU-side requests are dropped in reset. A read that collides with a write loses.
  assign inst_req_s = read_inst_enable && !rst;
  assign data_wr_s  = write_data_enable && !rst;
  assign data_req_s = read_data_enable && !write_data_enable && !rst;

  // Program-load write. Stays live during reset so a program can be loaded while the CPU is held.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_inst[prog_addr] <= prog_data;
    end
  end

  // CPU data write. Reads sampled at the same edge still see the old word.
  always_ff @(posedge clk) begin
    if (data_wr_s) begin
      mem_data[address_memory_data] <= memory_data_out;
    end
  end

  // Flag simultaneous data read and write with a one-cycle strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      err_conflict <= 1'b0;
    end else begin
      err_conflict <= read_data_enable && write_data_enable;
    end
  end

  cpu_mem_read_pipe #(
    .WIDTH  (WIDTH_DATA),
    .LATENCY(READ_LATENCY)
  ) u_inst_pipe (
    .clk  (clk),
    .rst  (rst),
    .req  (inst_req_s),
    .rdata(mem_inst[address_memory_inst]),
    .valid(inst_valid),
    .data (instruction)
  );

  cpu_mem_read_pipe #(
    .WIDTH  (WIDTH_DATA),
    .LATENCY(READ_LATENCY)
  ) u_data_pipe (
    .clk  (clk),
    .rst  (rst),
    .req  (data_req_s),
    .rdata(mem_data[address_memory_data]),
    .valid(data_valid),
    .data (memory_data_in)
  );

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder. Three instances with
// READ_LATENCY 1, 2 and 3 receive the same stimulus. Each request pushes
// its word and due cycle into a per-instance queue. A negedge monitor pops
// and compares the queue whenever a valid or err_conflict strobe appears.
module tb_cpu_mem_responder;

  typedef struct packed {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        read_inst_enable;
  logic [4:0]  address_memory_inst;
  logic        read_data_enable;
  logic        write_data_enable;
  logic [9:0]  address_memory_data;
  logic [31:0] memory_data_out;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [31:0] prog_data;

  logic [31:0] instruction_a [3];
  logic        inst_valid_a  [3];
  logic [31:0] mdin_a        [3];
  logic        data_valid_a  [3];
  logic        err_a         [3];

  exp_t qi [3][$];
  exp_t qd [3][$];
  int   qc [3][$];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      cpu_mem_responder #(
        .WIDTH_DATA(32), .AWIDTH(5), .DAWIDTH(10), .READ_LATENCY(g + 1)
      ) dut (
        .clk                (clk),
        .rst                (rst),
        .read_inst_enable   (read_inst_enable),
        .address_memory_inst(address_memory_inst),
        .instruction        (instruction_a[g]),
        .inst_valid         (inst_valid_a[g]),
        .read_data_enable   (read_data_enable),
        .write_data_enable  (write_data_enable),
        .address_memory_data(address_memory_data),
        .memory_data_out    (memory_data_out),
        .memory_data_in     (mdin_a[g]),
        .data_valid         (data_valid_a[g]),
        .prog_we            (prog_we),
        .prog_addr          (prog_addr),
        .prog_data          (prog_data),
        .err_conflict       (err_a[g])
      );
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest pending expectation in both value and cycle
  always @(negedge clk) begin
    exp_t e;
    int   d;
    for (int j = 0; j < 3; j++) begin
      if (inst_valid_a[j]) begin
        vectors++;
        if (qi[j].size() == 0) begin
          miscompares++;
          $display("FAIL inst_unexpected L=%0d: inst_valid at cycle %0d, none required", j + 1, cyc);
        end else begin
          e = qi[j].pop_front();
          if (instruction_a[j] !== e.data || cyc != e.due) begin
            miscompares++;
            $display("FAIL inst_resp L=%0d: got %h at cycle %0d, required %h at cycle %0d",
                     j + 1, instruction_a[j], cyc, e.data, e.due);
          end
        end
      end
      if (data_valid_a[j]) begin
        vectors++;
        if (qd[j].size() == 0) begin
          miscompares++;
          $display("FAIL data_unexpected L=%0d: data_valid at cycle %0d, none required", j + 1, cyc);
        end else begin
          e = qd[j].pop_front();
          if (mdin_a[j] !== e.data || cyc != e.due) begin
            miscompares++;
            $display("FAIL data_resp L=%0d: got %h at cycle %0d, required %h at cycle %0d",
                     j + 1, mdin_a[j], cyc, e.data, e.due);
          end
        end
      end
      if (err_a[j]) begin
        vectors++;
        if (qc[j].size() == 0) begin
          miscompares++;
          $display("FAIL conflict_unexpected L=%0d: err_conflict at cycle %0d", j + 1, cyc);
        end else begin
          d = qc[j].pop_front();
          if (cyc != d) begin
            miscompares++;
            $display("FAIL conflict_time L=%0d: at cycle %0d, required cycle %0d", j + 1, cyc, d);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    read_inst_enable  = 1'b0;
    read_data_enable  = 1'b0;
    write_data_enable = 1'b0;
    prog_we           = 1'b0;
  endtask

  task automatic chk(input string name, input int j, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s L=%0d: got %h, required %h", name, j + 1, got, req);
    end
  endtask

  task automatic rd_inst(input logic [4:0] a, input logic [31:0] e);
    read_inst_enable    = 1'b1;
    address_memory_inst = a;
    for (int j = 0; j < 3; j++) qi[j].push_back('{data: e, due: cyc + 2 + j});
  endtask

  task automatic rd_data(input logic [9:0] a, input logic [31:0] e);
    read_data_enable    = 1'b1;
    address_memory_data = a;
    for (int j = 0; j < 3; j++) qd[j].push_back('{data: e, due: cyc + 2 + j});
  endtask

  task automatic wr_data(input logic [9:0] a, input logic [31:0] d);
    write_data_enable   = 1'b1;
    address_memory_data = a;
    memory_data_out     = d;
  endtask

  task automatic prog(input logic [4:0] a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
  endtask

  // Wait for all queues to empty; a response that never arrives is a miscompare
  task automatic drain();
    int pending;
    for (int t = 0; t < 20; t++) begin
      pending = 0;
      for (int j = 0; j < 3; j++) pending += qi[j].size() + qd[j].size() + qc[j].size();
      if (pending == 0) break;
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      if (qi[j].size() + qd[j].size() + qc[j].size() != 0) begin
        vectors++;
        miscompares++;
        $display("FAIL drain_timeout L=%0d: %0d responses still pending, required 0",
                 j + 1, qi[j].size() + qd[j].size() + qc[j].size());
        qi[j].delete();
        qd[j].delete();
        qc[j].delete();
      end
    end
  endtask

  // Reset sampled at edge k drops every response due at or after k
  task automatic flush_from(input int k);
    for (int j = 0; j < 3; j++) begin
      while (qi[j].size() > 0 && qi[j][qi[j].size() - 1].due >= k) void'(qi[j].pop_back());
      while (qd[j].size() > 0 && qd[j][qd[j].size() - 1].due >= k) void'(qd[j].pop_back());
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int j = 0; j < 3; j++) begin
      chk({tag, "_instruction"}, j, instruction_a[j], 32'h0);
      chk({tag, "_inst_valid"}, j, {31'h0, inst_valid_a[j]}, 32'h0);
      chk({tag, "_memory_data_in"}, j, mdin_a[j], 32'h0);
      chk({tag, "_data_valid"}, j, {31'h0, data_valid_a[j]}, 32'h0);
      chk({tag, "_err_conflict"}, j, {31'h0, err_a[j]}, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] prog_words [5];
    prog_words[0] = 32'h0800_0005;
    prog_words[1] = 32'h0800_0003;
    prog_words[2] = 32'h2000_0000;
    prog_words[3] = 32'h7000_0000;
    prog_words[4] = 32'h0000_1234;

    rst                 = 1'b1;
    address_memory_inst = 5'd0;
    address_memory_data = 10'd0;
    memory_data_out     = 32'h0;
    prog_addr           = 5'd0;
    prog_data           = 32'h0;
    idle();
    tick();
    tick();
    chk_all_zero("reset");

    // Program load during reset; CPU reads issued meanwhile must be ignored
    for (int i = 0; i < 5; i++) begin
      prog(i[4:0], prog_words[i]);
      read_inst_enable    = 1'b1;
      address_memory_inst = 5'd2;
      read_data_enable    = 1'b1;
      tick();
    end
    idle();
    tick();
    rst = 1'b0;
    tick();

    // Test 1: instruction fetch of addr 2
    rd_inst(5'd2, 32'h2000_0000);
    tick();
    idle();
    drain();

    // Test 2: write then read addr 0x3FF, output holds afterwards
    wr_data(10'h3FF, 32'hDEAD_BEEF);
    tick();
    idle();
    rd_data(10'h3FF, 32'hDEAD_BEEF);
    tick();
    idle();
    drain();
    for (int j = 0; j < 3; j++) begin
      chk("hold_memory_data_in", j, mdin_a[j], 32'hDEAD_BEEF);
      chk("hold_data_valid", j, {31'h0, data_valid_a[j]}, 32'h0);
    end

    // Test 3: back-to-back reads of addr 1, 2, 3
    wr_data(10'd1, 32'h11); tick();
    wr_data(10'd2, 32'h22); tick();
    wr_data(10'd3, 32'h33); tick();
    idle();
    rd_data(10'd1, 32'h11); tick();
    rd_data(10'd2, 32'h22); tick();
    rd_data(10'd3, 32'h33); tick();
    idle();
    drain();

    // Test 4: read and write of addr 5 in the same cycle
    wr_data(10'd5, 32'h0);
    tick();
    wr_data(10'd5, 32'h55);
    read_data_enable = 1'b1;
    for (int j = 0; j < 3; j++) qc[j].push_back(cyc + 1);
    tick();
    idle();
    drain();
    rd_data(10'd5, 32'h55);
    tick();
    idle();
    drain();

    // Test 5: reset with a read in flight
    wr_data(10'd9, 32'h99);
    tick();
    idle();
    rd_data(10'd9, 32'h99);
    tick();
    idle();
    rst = 1'b1;
    flush_from(cyc + 1);
    tick();
    chk_all_zero("midreset");
    wr_data(10'd9, 32'h0000_0BAD);
    tick();
    idle();
    read_data_enable = 1'b1;
    tick();
    idle();
    tick();
    tick();
    rst = 1'b0;
    tick();
    rd_data(10'd9, 32'h99);
    tick();
    idle();
    drain();

    // Test 6: program write and fetch of the same address in one cycle
    prog(5'd4, 32'hAAAA_AAAA);
    rd_inst(5'd4, 32'h0000_1234);
    tick();
    idle();
    rd_inst(5'd4, 32'hAAAA_AAAA);
    tick();
    idle();
    drain();

    tick();
    tick();
    for (int j = 0; j < 3; j++) begin
      chk("leftover_inst", j, qi[j].size(), 32'd0);
      chk("leftover_data", j, qd[j].size(), 32'd0);
      chk("leftover_conflict", j, qc[j].size(), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
